window_linebuffer: RTL and testbench
====================================

Name: window_linebuffer

Overview:
Streaming KW x KW sliding-window generator for the video processing pipeline. It accepts one pixel per handshake in raster order and stores the previous KW-1 lines in chained line memories. It emits one registered KW x KW neighbourhood per accepted pixel once a full window exists. Convolution and filter stages consume its output directly, with ready/valid backpressure and frame/line markers.

Parameters:
DW, 12, pixel width in bits
RL, 640, pixels per line (line length), RL >= KW
KW, 3, window side (kernel size), KW >= 2

Ports:
i_clk  input  1  clock
i_rstn  input  1  synchronous active-low reset
i_valid  input  1  input pixel valid
o_ready  output  1  block can accept an input pixel
i_sof  input  1  marks the pixel as first of frame; qualified by i_valid
i_data  input  DW  input pixel
o_valid  output  1  output window valid
i_ready  input  1  downstream accepts the window
o_data  output  KW*KW*DW  flattened window
o_sof  output  1  first window of frame; qualified by o_valid
o_eol  output  1  last window of line; qualified by o_valid

Behaviour:
- Reset: i_rstn, synchronous, active-low; clock i_clk. On reset o_valid=0, o_data=0, o_sof=0, o_eol=0, col=0, rowcnt=0, first-window flag=1. Reset mid-operation discards any pending window. Line memory contents are not cleared; they are never exposed until refilled.
- Accept = i_valid && o_ready. o_ready = !o_valid || i_ready, combinational, single output stage. Full throughput is one pixel per cycle.
- Effective column: ecol = i_sof ? 0 : col.
- On accept, the column vector is v = {mem[KW-2][ecol], ..., mem[0][ecol], i_data}. Memories are read asynchronously (first-word-fall-through).
- On accept, memory writes: mem[0][ecol] <= i_data and mem[k][ecol] <= mem[k-1][ecol] for k >= 1.
- On accept, the window shift register (KW columns) shifts left and v enters as the rightmost column.
- col: increments on accept and wraps RL-1 -> 0. If i_sof is set, col <= 1 (or 0 when RL=1, which is excluded by RL >= KW >= 2).
- rowcnt: on wrap, increments and saturates at KW-1. If i_sof is set, rowcnt <= 0.
- Emit condition, evaluated on accept: rowcnt_eff == KW-1 && ecol >= KW-1, where rowcnt_eff = i_sof ? 0 : rowcnt.
- Latency: the window containing the accepted pixel appears with o_valid=1 on the next cycle.
- Output hold: o_data, o_sof and o_eol are registered and held stable while o_valid && !i_ready. o_valid clears on i_ready when no new window is emitted.
- Window packing: element (r,c), with r=0 the oldest row and c=0 the oldest column, sits at o_data[(KW*KW-1-(r*KW+c))*DW +: DW]. The top-left pixel occupies the MSBs and the newest pixel occupies the LSBs.
- Windows per line: RL-KW+1. There is no border padding.
- o_eol = 1 when the emitting pixel has ecol == RL-1.
- o_sof = 1 on the first window after i_sof (or after reset); the first-window flag then clears. i_sof re-arms the flag.
- i_sof mid-line or mid-frame: an abort-and-restart. Partial rows are discarded logically, and no window is emitted until KW-1 fresh rows plus KW-1 columns have been accepted.
- Simultaneous i_sof with a pending stalled output: the pending window is held until taken. The new pixel is accepted only when o_ready=1.

Test Plan:
- Basic fill (DW=8, RL=8, KW=3; pixel = y*16+x, i_sof on pixel (0,0); i_ready=1) -> first o_valid the cycle after pixel 0x22 is accepted. o_data = 00,01,02,10,11,12,20,21,22 (MSB to LSB) with o_sof=1. 6 windows per line from row 2. o_eol=1 on the window ending at x=7 (top-left 0x05).
- Row wrap, same stream -> the first window of row 3 is 10,11,12,20,21,22,30,31,32 with o_sof=0. No window is emitted for x=0,1 of any row.
- Backpressure: hold i_ready=0 for 5 cycles after the first window -> o_ready=0, o_data stays 00..22, and no input is consumed. Releasing i_ready gives the next window 01,02,03,11,12,13,21,22,23.
- Mid-frame i_sof at row 4, x=3 -> no o_valid for the next 2*8+2 accepted pixels. The next window has o_sof=1 and contains only new-frame pixels.
- Reset asserted mid-line with o_valid=1 -> the next cycle gives o_valid=0, o_sof=0, o_eol=0, o_data=0. After restart the behaviour matches the basic fill scenario.
- KW=5, RL=16 -> the first window appears after pixel (4,4), 25 elements packed top-left MSB, 12 windows per line.

Source files
------------

// File: rtl/window_linebuffer_if.sv
// Pixel-in / window-out stream bundle for window_linebuffer.
// The block uses the slave modport; the pixel source and window sink use master.
interface window_linebuffer_if #(
  parameter int DW = 12,
  parameter int KW = 3
) ();
  logic                   i_valid;
  logic                   o_ready;
  logic                   i_sof;
  logic [DW-1:0]          i_data;
  logic                   o_valid;
  logic                   i_ready;
  logic [KW*KW*DW-1:0]    o_data;
  logic                   o_sof;
  logic                   o_eol;

  modport slave (
    input  i_valid, i_sof, i_data, i_ready,
    output o_ready, o_valid, o_data, o_sof, o_eol
  );

  modport master (
    output i_valid, i_sof, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_sof, o_eol
  );
endinterface

// File: rtl/window_linebuffer.sv
// Streaming KW x KW sliding-window generator: KW-1 chained line memories feed a
// column shift register, and one registered window is emitted per accepted pixel.
module window_linebuffer #(
  parameter int DW = 12,
  parameter int RL = 640,
  parameter int KW = 3
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  window_linebuffer_if.slave bus
);
  localparam int CW = (RL > 1) ? $clog2(RL) : 1;
  localparam int RW = $clog2(KW);
  localparam int NW = KW * KW * DW;

  logic [CW-1:0]                  col;
  logic [CW-1:0]                  ecol;
  logic [RW-1:0]                  rowcnt;
  logic [RW-1:0]                  rowcnt_eff;
  logic                           first_win;
  logic                           accept;
  logic                           emit;
  logic [DW-1:0]                  mem [KW-1][RL];
  logic [KW-1:0][DW-1:0]          col_vec;
  logic [KW-1:0][KW-1:0][DW-1:0]  win_q;
  logic [KW-1:0][KW-1:0][DW-1:0]  win_d;
  logic [NW-1:0]                  win_flat;

  assign bus.o_ready = !bus.o_valid || bus.i_ready;
  assign accept      = bus.i_valid && bus.o_ready;

  // A start-of-frame pixel restarts the raster at column 0, row 0.
  assign ecol       = bus.i_sof ? '0 : col;
  assign rowcnt_eff = bus.i_sof ? '0 : rowcnt;
  assign emit       = accept && (rowcnt_eff == RW'(KW - 1)) && (ecol >= CW'(KW - 1));

  // Row 0 of the column is the oldest line (deepest memory), row KW-1 is the live pixel.
  always_comb begin
    col_vec         = '0;
    col_vec[KW-1]   = bus.i_data;
    for (int r = 0; r < KW - 1; r++) begin
      col_vec[r] = mem[KW-2-r][ecol];
    end
  end

  always_comb begin
    win_d = win_q;
    for (int r = 0; r < KW; r++) begin
      for (int c = 0; c < KW - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][KW-1] = col_vec[r];
    end
  end

  // Top-left element lands in the MSBs, the newest pixel in the LSBs.
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < KW; r++) begin
      for (int c = 0; c < KW; c++) begin
        win_flat[(KW*KW-1-(r*KW+c))*DW +: DW] = win_d[r][c];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rstn && accept) begin
      mem[0][ecol] <= bus.i_data;
      for (int k = 1; k < KW - 1; k++) begin
        mem[k][ecol] <= mem[k-1][ecol];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      col       <= '0;
      rowcnt    <= '0;
      first_win <= 1'b1;
      win_q     <= '0;
    end else if (accept) begin
      win_q <= win_d;
      if (bus.i_sof) begin
        col    <= CW'(1);
        rowcnt <= '0;
      end else if (col == CW'(RL - 1)) begin
        col <= '0;
        if (rowcnt != RW'(KW - 1)) begin
          rowcnt <= rowcnt + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
      if (emit) begin
        first_win <= 1'b0;
      end else if (bus.i_sof) begin
        first_win <= 1'b1;
      end
    end
  end

  // Output stage only loads on emit, so a stalled window stays put until taken.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_sof   <= 1'b0;
      bus.o_eol   <= 1'b0;
    end else if (emit) begin
      bus.o_valid <= 1'b1;
      bus.o_data  <= win_flat;
      bus.o_sof   <= first_win;
      bus.o_eol   <= (ecol == CW'(RL - 1));
    end else if (bus.i_ready) begin
      bus.o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_linebuffer.sv
// Directed bench for window_linebuffer: a KW=3/RL=8 instance and a KW=5/RL=16 instance,
// fed with pixel = y*16+x so every expected window can be written down by hand.
module tb_window_linebuffer;
  logic clk = 1'b0;
  logic rstn;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  window_linebuffer_if #(.DW(8), .KW(3)) a_if ();
  window_linebuffer_if #(.DW(8), .KW(5)) b_if ();

  window_linebuffer #(.DW(8), .RL(8), .KW(3)) u_dut_a (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (a_if)
  );

  window_linebuffer #(.DW(8), .RL(16), .KW(5)) u_dut_b (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (b_if)
  );

  // Window whose newest pixel is (y,x); element (r,c) holds base + row*16 + column.
  function automatic logic [199:0] exp_win(int kw, int y, int x, int base);
    logic [199:0] w;
    w = '0;
    for (int r = 0; r < kw; r++) begin
      for (int c = 0; c < kw; c++) begin
        w[(kw*kw-1-(r*kw+c))*8 +: 8] = 8'(base + (y - kw + 1 + r) * 16 + (x - kw + 1 + c));
      end
    end
    return w;
  endfunction

  task automatic drive_a(input logic sof, input logic [7:0] d);
    a_if.i_valid = 1'b1;
    a_if.i_sof   = sof;
    a_if.i_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_if.i_valid = 1'b0;
    a_if.i_sof   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic sof, input logic [7:0] d);
    b_if.i_valid = 1'b1;
    b_if.i_sof   = sof;
    b_if.i_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_b();
    b_if.i_valid = 1'b0;
    b_if.i_sof   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    a_if.i_valid = 1'b0; a_if.i_sof = 1'b0; a_if.i_data = '0; a_if.i_ready = 1'b1;
    b_if.i_valid = 1'b0; b_if.i_sof = 1'b0; b_if.i_data = '0; b_if.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (a_if.o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", a_if.o_valid); end
    tests_run++; if (a_if.o_sof !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sof: got %b expected 0", a_if.o_sof); end
    tests_run++; if (a_if.o_eol !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_eol: got %b expected 0", a_if.o_eol); end
    tests_run++; if (a_if.o_data !== 72'h0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h expected 0", a_if.o_data); end
    tests_run++; if (a_if.o_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 1", a_if.o_ready); end
    tests_run++; if (b_if.o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_b_valid: got %b expected 0", b_if.o_valid); end
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_fill();
    int nwin_row2 = 0;
    int nwin      = 0;
    logic exp_v;
    logic [199:0] e;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        drive_a(y == 0 && x == 0, 8'(y * 16 + x));
        exp_v = (y >= 2) && (x >= 2);
        tests_run++; if (a_if.o_valid !== exp_v) begin tests_failed++; $display("[TB] FAIL fill_valid y=%0d x=%0d: got %b expected %b", y, x, a_if.o_valid, exp_v); end
        if (exp_v) begin
          nwin++;
          if (y == 2) nwin_row2++;
          e = exp_win(3, y, x, 0);
          tests_run++; if (a_if.o_data !== e[71:0]) begin tests_failed++; $display("[TB] FAIL fill_data y=%0d x=%0d: got %h expected %h", y, x, a_if.o_data, e[71:0]); end
          tests_run++; if (a_if.o_sof !== (y == 2 && x == 2)) begin tests_failed++; $display("[TB] FAIL fill_sof y=%0d x=%0d: got %b", y, x, a_if.o_sof); end
          tests_run++; if (a_if.o_eol !== (x == 7)) begin tests_failed++; $display("[TB] FAIL fill_eol y=%0d x=%0d: got %b", y, x, a_if.o_eol); end
        end
        if (y == 2 && x == 2) begin
          tests_run++; if (a_if.o_data !== 72'h000102_101112_202122) begin tests_failed++; $display("[TB] FAIL fill_first: got %h expected 000102101112202122", a_if.o_data); end
        end
        if (y == 2 && x == 7) begin
          tests_run++; if (a_if.o_data !== 72'h050607_151617_252627 || a_if.o_eol !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill_eol_window: got %h eol=%b expected 050607151617252627 eol=1", a_if.o_data, a_if.o_eol); end
        end
        if (y == 3 && x == 2) begin
          tests_run++; if (a_if.o_data !== 72'h101112_202122_303132 || a_if.o_sof !== 1'b0) begin tests_failed++; $display("[TB] FAIL row_wrap: got %h sof=%b expected 101112202122303132 sof=0", a_if.o_data, a_if.o_sof); end
        end
      end
    end
    tests_run++; if (nwin_row2 != 6) begin tests_failed++; $display("[TB] FAIL fill_row2_count: got %0d expected 6", nwin_row2); end
    tests_run++; if (nwin != 36) begin tests_failed++; $display("[TB] FAIL fill_total_count: got %0d expected 36", nwin); end
    idle_a();
    tests_run++; if (a_if.o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_drain: got %b expected 0", a_if.o_valid); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 19; i++) drive_a(i == 0, 8'((i / 8) * 16 + i % 8));
    tests_run++; if (a_if.o_valid !== 1'b1 || a_if.o_data !== 72'h000102_101112_202122) begin tests_failed++; $display("[TB] FAIL bp_first: got v=%b %h expected v=1 000102101112202122", a_if.o_valid, a_if.o_data); end
    a_if.i_ready = 1'b0;
    a_if.i_valid = 1'b1;
    a_if.i_sof   = 1'b0;
    a_if.i_data  = 8'h23;
    #1;
    tests_run++; if (a_if.o_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_ready_drop: got %b expected 0", a_if.o_ready); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      tests_run++; if (a_if.o_valid !== 1'b1 || a_if.o_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_stall_hs k=%0d: got v=%b r=%b expected v=1 r=0", k, a_if.o_valid, a_if.o_ready); end
      tests_run++; if (a_if.o_data !== 72'h000102_101112_202122 || a_if.o_sof !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_hold k=%0d: got %h sof=%b expected 000102101112202122 sof=1", k, a_if.o_data, a_if.o_sof); end
    end
    a_if.i_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++; if (a_if.o_valid !== 1'b1 || a_if.o_data !== 72'h010203_111213_212223 || a_if.o_sof !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_release: got v=%b %h sof=%b expected v=1 010203111213212223 sof=0", a_if.o_valid, a_if.o_data, a_if.o_sof); end
    drive_a(1'b0, 8'h24);
    tests_run++; if (a_if.o_data !== 72'h020304_121314_222324) begin tests_failed++; $display("[TB] FAIL bp_next: got %h expected 020304121314222324", a_if.o_data); end
    idle_a();
  endtask

  task automatic test_midframe_sof();
    for (int i = 0; i < 35; i++) drive_a(i == 0, 8'((i / 8) * 16 + i % 8));
    tests_run++; if (a_if.o_valid !== 1'b1 || a_if.o_data !== 72'h202122_303132_404142) begin tests_failed++; $display("[TB] FAIL mid_before: got v=%b %h expected v=1 202122303132404142", a_if.o_valid, a_if.o_data); end
    for (int n = 0; n < 19; n++) begin
      drive_a(n == 0, 8'(8'h80 + (n / 8) * 16 + n % 8));
      if (n < 18) begin
        tests_run++; if (a_if.o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_quiet n=%0d: got %b expected 0", n, a_if.o_valid); end
      end else begin
        tests_run++; if (a_if.o_valid !== 1'b1 || a_if.o_sof !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_first_hs: got v=%b sof=%b expected 1 1", a_if.o_valid, a_if.o_sof); end
        tests_run++; if (a_if.o_data !== 72'h808182_909192_a0a1a2) begin tests_failed++; $display("[TB] FAIL mid_first_data: got %h expected 808182909192a0a1a2", a_if.o_data); end
      end
    end
    idle_a();
  endtask

  task automatic test_reset_midline();
    logic exp_v;
    for (int i = 0; i < 21; i++) drive_a(i == 0, 8'((i / 8) * 16 + i % 8));
    tests_run++; if (a_if.o_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_pre_valid: got %b expected 1", a_if.o_valid); end
    a_if.i_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    tests_run++; if (a_if.o_valid !== 1'b0 || a_if.o_sof !== 1'b0 || a_if.o_eol !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_flags: got v=%b sof=%b eol=%b expected 0 0 0", a_if.o_valid, a_if.o_sof, a_if.o_eol); end
    tests_run++; if (a_if.o_data !== 72'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_data: got %h expected 0", a_if.o_data); end
    rstn = 1'b1;
    for (int i = 0; i < 24; i++) begin
      drive_a(i == 0, 8'((i / 8) * 16 + i % 8));
      exp_v = (i / 8 == 2) && (i % 8 >= 2);
      tests_run++; if (a_if.o_valid !== exp_v) begin tests_failed++; $display("[TB] FAIL rst_refill_valid i=%0d: got %b expected %b", i, a_if.o_valid, exp_v); end
      if (i == 18) begin
        tests_run++; if (a_if.o_data !== 72'h000102_101112_202122 || a_if.o_sof !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_refill_first: got %h sof=%b expected 000102101112202122 sof=1", a_if.o_data, a_if.o_sof); end
      end
      if (i == 23) begin
        tests_run++; if (a_if.o_eol !== 1'b1 || a_if.o_data !== 72'h050607_151617_252627) begin tests_failed++; $display("[TB] FAIL rst_refill_eol: got %h eol=%b expected 050607151617252627 eol=1", a_if.o_data, a_if.o_eol); end
      end
    end
    idle_a();
  endtask

  task automatic test_kw5();
    int nrow4 = 0;
    logic exp_v;
    logic [199:0] e;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 16; x++) begin
        drive_b(y == 0 && x == 0, 8'(y * 16 + x));
        exp_v = (y >= 4) && (x >= 4);
        tests_run++; if (b_if.o_valid !== exp_v) begin tests_failed++; $display("[TB] FAIL kw5_valid y=%0d x=%0d: got %b expected %b", y, x, b_if.o_valid, exp_v); end
        if (exp_v) begin
          if (y == 4) nrow4++;
          e = exp_win(5, y, x, 0);
          tests_run++; if (b_if.o_data !== e) begin tests_failed++; $display("[TB] FAIL kw5_data y=%0d x=%0d: got %h expected %h", y, x, b_if.o_data, e); end
          tests_run++; if (b_if.o_sof !== (y == 4 && x == 4) || b_if.o_eol !== (x == 15)) begin tests_failed++; $display("[TB] FAIL kw5_marks y=%0d x=%0d: got sof=%b eol=%b", y, x, b_if.o_sof, b_if.o_eol); end
        end
        if (y == 4 && x == 4) begin
          tests_run++; if (b_if.o_data !== 200'h0001020304_1011121314_2021222324_3031323334_4041424344) begin tests_failed++; $display("[TB] FAIL kw5_first: got %h", b_if.o_data); end
        end
      end
    end
    tests_run++; if (nrow4 != 12) begin tests_failed++; $display("[TB] FAIL kw5_row_count: got %0d expected 12", nrow4); end
    idle_b();
    tests_run++; if (b_if.o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL kw5_drain: got %b expected 0", b_if.o_valid); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic_fill();
    test_backpressure();
    test_midframe_sof();
    test_reset_midline();
    test_kw5();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
